// File: rtl/store_drain.sv
// Store-buffer drain: pops entries from the synchronous store FIFO and issues each as one req/ack write.
// Optional ack watchdog built when STORE_DRAIN_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no store in flight; pop when enabled and FIFO non-empty
// LOAD  | FIFO read data valid this cycle; capture fields into request regs
// REQ   | write request outstanding; wait for ack (or watchdog expiry)
module store_drain #(
    parameter int ADDR_WIDTH     = 32,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 drain_en,
    input  logic [XLEN/8+ADDR_WIDTH+XLEN-1:0]    fifo_buf_out,
    input  logic                                 fifo_buf_empty,
    output logic                                 fifo_rd_en,
    output logic                                 mem_wr_req,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [XLEN-1:0]                      mem_wdata,
    output logic [XLEN/8-1:0]                    mem_be,
    input  logic                                 mem_wr_ack,
    output logic                                 drain_idle,
    output logic [15:0]                          drained_count,
    output logic                                 drain_err
);
    localparam int BE_W    = XLEN / 8;
    localparam int ENTRY_W = BE_W + ADDR_WIDTH + XLEN;

    typedef enum logic [1:0] {IDLE, LOAD, REQ} state_t;

    state_t state, state_nxt;
    logic   pop_ok;
    logic   load_fields;
    logic   ack_done;
    logic   timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        fifo_rd_en  = 1'b0;
        load_fields = 1'b0;
        ack_done    = 1'b0;
        // Reset is synchronous, so gate the pop here to keep the FIFO untouched while reset is held.
        pop_ok      = rst_n && drain_en && !fifo_buf_empty;
        case (state)
            IDLE: begin
                if (pop_ok) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                load_fields = 1'b1;
                state_nxt   = REQ;
            end
            REQ: begin
                if (mem_wr_ack) begin
                    ack_done = 1'b1;
                    if (pop_ok) begin
                        fifo_rd_en = 1'b1;
                        state_nxt  = LOAD;
                    end else begin
                        state_nxt  = IDLE;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wr_req <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_wr_req <= (state_nxt == REQ);
            if (load_fields) begin
                mem_be    <= fifo_buf_out[ENTRY_W-1 -: BE_W];
                mem_addr  <= fifo_buf_out[XLEN +: ADDR_WIDTH];
                mem_wdata <= fifo_buf_out[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        drained_count <= '0;
        else if (ack_done) drained_count <= drained_count + 16'd1;
    end

    assign drain_idle = (state == IDLE) && fifo_buf_empty;

`ifdef STORE_DRAIN_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] wd_cnt;

    // Fires on the cycle that would be the TIMEOUT_CYCLES-th REQ cycle without ack.
    assign timeout = (state == REQ) && !mem_wr_ack && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            drain_err <= 1'b0;
        end else begin
            if (state == REQ && !mem_wr_ack) wd_cnt <= wd_cnt + 1'b1;
            else                             wd_cnt <= '0;
            if (timeout) drain_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign drain_err          = 1'b0;
`endif

endmodule

// File: tb/tb_store_drain.sv
// Self-checking bench for store_drain: behavioural FIFO model feeding the DUT, scoreboard of expected writes.
// Builds the watchdog scenario when STORE_DRAIN_TIMEOUT_EN is defined.
module tb_store_drain;
    localparam int AW = 32;
    localparam int XL = 32;
    localparam int BW = XL / 8;
    localparam int EW = BW + AW + XL;
`ifdef STORE_DRAIN_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          drain_en = 1'b0;
    logic [EW-1:0] fifo_buf_out = '0;
    logic          fifo_buf_empty = 1'b1;
    logic          fifo_rd_en;
    logic          mem_wr_req;
    logic [AW-1:0] mem_addr;
    logic [XL-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_wr_ack = 1'b0;
    logic          drain_idle;
    logic [15:0]   drained_count;
    logic          drain_err;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] fifo_q[$];
    logic [EW-1:0] exp_q[$];

    store_drain #(.ADDR_WIDTH(AW), .XLEN(XL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .drain_en(drain_en),
        .fifo_buf_out(fifo_buf_out), .fifo_buf_empty(fifo_buf_empty), .fifo_rd_en(fifo_rd_en),
        .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_wr_ack(mem_wr_ack), .drain_idle(drain_idle), .drained_count(drained_count),
        .drain_err(drain_err)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read, data held until the next pop.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_when_empty got rd_en=1 expected 0");
            end else begin
                fifo_buf_out <= fifo_q.pop_front();
            end
            #1 fifo_buf_empty = (fifo_q.size() == 0);
        end
    end

    // Scoreboard: every accepted write must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && mem_wr_req && mem_wr_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got %h expected none", {mem_be, mem_addr, mem_wdata});
            end else if ({mem_be, mem_addr, mem_wdata} !== exp_q[0]) begin
                errors++;
                $display("FAIL sb_entry got %h expected %h", {mem_be, mem_addr, mem_wdata}, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_entry(input logic [BW-1:0] be, input logic [AW-1:0] addr, input logic [XL-1:0] data);
        fifo_q.push_back({be, addr, data});
        exp_q.push_back({be, addr, data});
        fifo_buf_empty = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        rst_n      = 1'b0;
        mem_wr_ack = 1'b0;
        drain_en   = 1'b1;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (drain_idle) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        cyc();
        rst_n = 1'b0; drain_en = 1'b1; mem_wr_ack = 1'b0;
        push_entry(4'h1, 32'h0000_0100, 32'h1111_1111);
        push_entry(4'h3, 32'h0000_0104, 32'h2222_2222);
        push_entry(4'h7, 32'h0000_0108, 32'h3333_3333);
        repeat (3) cyc();
        @(negedge clk);
        checks++;
        if ({fifo_rd_en, mem_wr_req, drain_err, drain_idle} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 0000", {fifo_rd_en, mem_wr_req, drain_err, drain_idle});
        end
        checks++;
        if ({mem_be, mem_addr, mem_wdata, drained_count} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0", {mem_be, mem_addr, mem_wdata, drained_count});
        end
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({fifo_rd_en, mem_wr_req} !== 2'b10) begin
            errors++;
            $display("FAIL first_pop got %b expected 10", {fifo_rd_en, mem_wr_req});
        end
        cyc(); @(negedge clk);
        checks++;
        if ({fifo_rd_en, mem_wr_req} !== 2'b00) begin
            errors++;
            $display("FAIL load_cycle got %b expected 00", {fifo_rd_en, mem_wr_req});
        end
        cyc(); @(negedge clk);
        checks++;
        if (mem_wr_req !== 1'b1 || mem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL req_latency got req=%b addr=%h expected req=1 addr=00000100", mem_wr_req, mem_addr);
        end
        cyc(); rst_n = 1'b0;
        cyc(); @(negedge clk);
        checks++;
        if (mem_wr_req !== 1'b0 || drained_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_req got req=%b cnt=%0d expected req=0 cnt=0", mem_wr_req, drained_count);
        end
        void'(exp_q.pop_front());
        cyc(); rst_n = 1'b1; mem_wr_ack = 1'b1;
        wait_idle(50, ok);
        checks++;
        if (!ok || drained_count !== 16'd2) begin
            errors++;
            $display("FAIL reset_drain got idle=%b cnt=%0d expected idle=1 cnt=2", ok, drained_count);
        end
        cyc(); mem_wr_ack = 1'b0;
    endtask

    task automatic test_single_store();
        do_reset();
        push_entry(4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_wr_req, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL single_hold[%0d] got %h expected 1f00001000deadbeef", k,
                         {mem_wr_req, mem_be, mem_addr, mem_wdata});
            end
            cyc();
        end
        mem_wr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_wr_req !== 1'b1 || drained_count !== 16'd0) begin
            errors++;
            $display("FAIL single_ack got req=%b cnt=%0d expected req=1 cnt=0", mem_wr_req, drained_count);
        end
        cyc(); mem_wr_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_wr_req, drain_idle} !== 2'b01 || drained_count !== 16'd1) begin
            errors++;
            $display("FAIL single_done got req/idle=%b cnt=%0d expected 01 cnt=1", {mem_wr_req, drain_idle}, drained_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] req_hist;
        logic [15:0] rd_hist;
        do_reset();
        mem_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++)
            push_entry(4'(i + 1), 32'h0000_2000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req_hist[i] = mem_wr_req;
            rd_hist[i]  = fifo_rd_en;
        end
        checks++;
        if (req_hist !== 16'h0154) begin
            errors++;
            $display("FAIL b2b_req_pattern got %h expected 0154", req_hist);
        end
        checks++;
        if (rd_hist !== 16'h0055) begin
            errors++;
            $display("FAIL b2b_pop_pattern got %h expected 0055", rd_hist);
        end
        checks++;
        if (drained_count !== 16'd4 || drain_idle !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count got cnt=%0d idle=%b expected cnt=4 idle=1", drained_count, drain_idle);
        end
        cyc(); mem_wr_ack = 1'b0;
    endtask

    task automatic test_drain_en_pause();
        bit ok;
        do_reset();
        push_entry(4'hC, 32'h0000_3000, 32'h0BAD_F00D);
        push_entry(4'h3, 32'h0000_3004, 32'h1234_5678);
        push_entry(4'h6, 32'h0000_3008, 32'h9ABC_DEF0);
        cyc(); cyc();
        drain_en = 1'b0;
        cyc(); cyc();
        mem_wr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_wr_req, fifo_rd_en} !== 2'b10) begin
            errors++;
            $display("FAIL pause_ack got req/rd=%b expected 10", {mem_wr_req, fifo_rd_en});
        end
        cyc(); mem_wr_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_wr_req, drain_idle} !== 2'b00 || drained_count !== 16'd1) begin
            errors++;
            $display("FAIL pause_done got req/idle=%b cnt=%0d expected 00 cnt=1", {mem_wr_req, drain_idle}, drained_count);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(); @(negedge clk);
            checks++;
            if ({fifo_rd_en, mem_wr_req, drain_idle} !== 3'b000) begin
                errors++;
                $display("FAIL pause_hold[%0d] got %b expected 000", k, {fifo_rd_en, mem_wr_req, drain_idle});
            end
        end
        cyc(); drain_en = 1'b1; mem_wr_ack = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok || drained_count !== 16'd3) begin
            errors++;
            $display("FAIL pause_resume got idle=%b cnt=%0d expected idle=1 cnt=3", ok, drained_count);
        end
        cyc(); mem_wr_ack = 1'b0;
    endtask

    task automatic test_counter_wrap();
        bit ok;
        do_reset();
        cyc();
        force dut.drained_count = 16'hFFFF;
        cyc();
        release dut.drained_count;
        @(negedge clk);
        checks++;
        if (drained_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h expected ffff", drained_count);
        end
        cyc();
        mem_wr_ack = 1'b1;
        push_entry(4'h5, 32'h0000_4000, 32'hCAFE_0001);
        wait_idle(20, ok);
        checks++;
        if (!ok || drained_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap got idle=%b cnt=%h expected idle=1 cnt=0000", ok, drained_count);
        end
        cyc(); mem_wr_ack = 1'b0;
    endtask

`ifdef STORE_DRAIN_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int req_cycles;
        do_reset();
        push_entry(4'h9, 32'h0000_5000, 32'h7777_0000);
        push_entry(4'hA, 32'h0000_5004, 32'h7777_0001);
        cyc(); cyc();
        req_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!mem_wr_req) begin
                ok = 1'b1;
                break;
            end
            req_cycles++;
        end
        checks++;
        if (!ok || req_cycles != 16) begin
            errors++;
            $display("FAIL timeout_len got dropped=%b cycles=%0d expected dropped=1 cycles=16", ok, req_cycles);
        end
        checks++;
        if (drain_err !== 1'b1 || drained_count !== 16'd0) begin
            errors++;
            $display("FAIL timeout_err got err=%b cnt=%0d expected err=1 cnt=0", drain_err, drained_count);
        end
        void'(exp_q.pop_front());
        cyc(); mem_wr_ack = 1'b1;
        wait_idle(20, ok);
        checks++;
        if (!ok || drained_count !== 16'd1 || drain_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover got idle=%b cnt=%0d err=%b expected 1/1/1", ok, drained_count, drain_err);
        end
        cyc(); mem_wr_ack = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        do_reset();
        push_entry(4'h9, 32'h0000_5000, 32'h7777_0000);
        repeat (300) cyc();
        @(negedge clk);
        checks++;
        if (mem_wr_req !== 1'b1 || drain_err !== 1'b0 || drained_count !== 16'd0) begin
            errors++;
            $display("FAIL no_timeout got req=%b err=%b cnt=%0d expected 1/0/0", mem_wr_req, drain_err, drained_count);
        end
        cyc(); mem_wr_ack = 1'b1;
        wait_idle(20, ok);
        checks++;
        if (!ok || drained_count !== 16'd1) begin
            errors++;
            $display("FAIL no_timeout_ack got idle=%b cnt=%0d expected idle=1 cnt=1", ok, drained_count);
        end
        cyc(); mem_wr_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_store();
        test_back_to_back();
        test_drain_en_pause();
        test_counter_wrap();
`ifdef STORE_DRAIN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (2) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
